// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and dimension/address-width helpers for conv_engine
package conv_pkg;

    typedef enum logic [2:0] {IDLE, BIAS, MAC, OUT, DONE} state_t;

    function automatic int out_dim(input int n, input int k, input int pad, input int stride);
        return (n + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: registered multiply-accumulate with bias load, accumulate enable and zero-operand forcing
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     en,
    input  logic                     zero,
    input  logic        [DATA_W-1:0] pix,
    input  logic signed [WGT_W-1:0]  wgt,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int P_W = DATA_W + WGT_W + 1;

    logic        [DATA_W-1:0] pix_z;
    logic signed [P_W-1:0]    pix_e;
    logic signed [P_W-1:0]    wgt_e;
    logic signed [P_W-1:0]    prod;

    assign pix_z = zero ? '0 : pix;
    assign pix_e = {{(WGT_W + 1){1'b0}}, pix_z};
    assign wgt_e = {{(DATA_W + 1){wgt[WGT_W-1]}}, wgt};
    assign prod  = pix_e * wgt_e;

    // bias load starts a pixel; afterwards each enabled cycle adds one sign-extended product (wrapping)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (load)
            acc <= bias;
        else if (en)
            acc <= acc + {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    end

endmodule

// File: rtl/conv_engine.sv
// conv_engine: convolution layer engine with one time-multiplexed MAC and per-channel bias.
// Optional ReLU on the output when CONV_ENGINE_RELU_EN is defined.
module conv_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 24,
    parameter int IN_H   = 16,
    parameter int IN_W   = 15,
    parameter int IN_CH  = 1,
    parameter int OUT_CH = 10,
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int STRIDE = 1,
    parameter int PAD    = 0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           img_rd_en,
    output logic [aw(IN_CH*IN_H*IN_W)-1:0]                 img_addr,
    input  logic [DATA_W-1:0]                              img_data,
    output logic                                           w_rd_en,
    output logic [aw(OUT_CH*IN_CH*K_H*K_W)-1:0]            w_addr,
    input  logic [WGT_W-1:0]                               w_data,
    output logic                                           b_rd_en,
    output logic [aw(OUT_CH)-1:0]                          b_addr,
    input  logic [ACC_W-1:0]                               b_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [ACC_W-1:0]                               out_data,
    output logic [aw(OUT_CH)-1:0]                          out_chan,
    output logic [aw(out_dim(IN_H, K_H, PAD, STRIDE))-1:0] out_row,
    output logic [aw(out_dim(IN_W, K_W, PAD, STRIDE))-1:0] out_col,
    output logic                                           chan_last
);

    localparam int OUT_H = out_dim(IN_H, K_H, PAD, STRIDE);
    localparam int OUT_W = out_dim(IN_W, K_W, PAD, STRIDE);
    localparam int IA_W  = aw(IN_CH * IN_H * IN_W);
    localparam int WA_W  = aw(OUT_CH * IN_CH * K_H * K_W);
    localparam int CA_W  = aw(OUT_CH);
    localparam int RA_W  = aw(OUT_H);
    localparam int LA_W  = aw(OUT_W);
    localparam int IC_W  = aw(IN_CH);
    localparam int KH_W  = aw(K_H);
    localparam int KW_W  = aw(K_W);

    state_t            state, state_nx;
    logic [CA_W-1:0]   oc;
    logic [RA_W-1:0]   orow;
    logic [LA_W-1:0]   ocol;
    logic [IC_W-1:0]   ic;
    logic [KH_W-1:0]   kh;
    logic [KW_W-1:0]   kw;
    logic              drain, ld, mac_v, pad_d;
    logic              pad, last_tap, last_px;
    logic [ACC_W-1:0]  acc;
    int                r, c;

    // input coordinates of the current tap and whether it lies in the zero border
    always_comb begin
        r         = int'(orow) * STRIDE - PAD + int'(kh);
        c         = int'(ocol) * STRIDE - PAD + int'(kw);
        pad       = r < 0 || r >= IN_H || c < 0 || c >= IN_W;
        img_addr  = pad ? '0 : IA_W'((int'(ic) * IN_H + r) * IN_W + c);
        w_addr    = WA_W'(((int'(oc) * IN_CH + int'(ic)) * K_H + int'(kh)) * K_W + int'(kw));
        last_tap  = ic == IC_W'(IN_CH - 1) && kh == KH_W'(K_H - 1) && kw == KW_W'(K_W - 1);
        last_px   = orow == RA_W'(OUT_H - 1) && ocol == LA_W'(OUT_W - 1);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and control outputs
    always_comb begin
        state_nx  = state;
        busy      = state == BIAS || state == MAC || state == OUT;
        done      = state == DONE;
        b_rd_en   = state == BIAS;
        w_rd_en   = state == MAC && !drain;
        img_rd_en = state == MAC && !drain && !pad;
        out_valid = state == OUT;
        chan_last = state == OUT && last_px;
        case (state)
            IDLE:    if (start) state_nx = BIAS;
            BIAS:    state_nx = MAC;
            MAC:     if (drain) state_nx = OUT;
            OUT:     if (out_ready) state_nx = (last_px && oc == CA_W'(OUT_CH - 1)) ? DONE : BIAS;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // tap and pixel counters plus the one-cycle read-to-MAC alignment flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {oc, orow, ocol, ic, kh, kw} <= '0;
            {drain, ld, mac_v, pad_d}    <= '0;
        end else begin
            ld    <= state == BIAS;
            mac_v <= w_rd_en;
            pad_d <= pad;
            if (state == IDLE && start)
                {oc, orow, ocol} <= '0;
            if (w_rd_en) begin
                drain <= last_tap;
                kw    <= kw == KW_W'(K_W - 1) ? '0 : kw + 1'b1;
                if (kw == KW_W'(K_W - 1)) begin
                    kh <= kh == KH_W'(K_H - 1) ? '0 : kh + 1'b1;
                    if (kh == KH_W'(K_H - 1))
                        ic <= ic == IC_W'(IN_CH - 1) ? '0 : ic + 1'b1;
                end
            end else if (state == MAC) begin
                drain <= 1'b0;
            end
            if (state == OUT && out_ready) begin
                ocol <= ocol == LA_W'(OUT_W - 1) ? '0 : ocol + 1'b1;
                if (ocol == LA_W'(OUT_W - 1)) begin
                    orow <= orow == RA_W'(OUT_H - 1) ? '0 : orow + 1'b1;
                    if (orow == RA_W'(OUT_H - 1))
                        oc <= oc == CA_W'(OUT_CH - 1) ? '0 : oc + 1'b1;
                end
            end
        end
    end

    assign b_addr   = oc;
    assign out_chan = oc;
    assign out_row  = orow;
    assign out_col  = ocol;

    mac_unit #(.DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld),
        .bias  (b_data),
        .en    (mac_v),
        .zero  (pad_d),
        .pix   (img_data),
        .wgt   (w_data),
        .acc   (acc)
    );

`ifdef CONV_ENGINE_RELU_EN
    assign out_data = acc[ACC_W-1] ? '0 : acc;
`else
    assign out_data = acc;
`endif

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: scoreboard bench for conv_engine (default and padded/strided instances)
module tb_conv_engine;

    typedef struct packed {
        logic [23:0] d;
        logic [3:0]  ch;
        logic [3:0]  r;
        logic [3:0]  c;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic [23:0] d;
        logic        ch;
        logic [2:0]  r;
        logic [2:0]  c;
        logic        last;
    } gexp_t;

`ifdef CONV_ENGINE_RELU_EN
    localparam int RELU_EXP = 0;
`else
    localparam int RELU_EXP = -1000;
`endif

    logic clk = 0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default instance
    logic               start, busy, done, img_rd_en, w_rd_en, b_rd_en;
    logic               out_valid, out_ready, chan_last;
    logic [7:0]         img_addr, img_data;
    logic [6:0]         w_addr;
    logic signed [7:0]  w_data;
    logic [3:0]         b_addr, out_chan, out_row, out_col;
    logic signed [23:0] b_data, out_data;

    logic [7:0]         img_mem [240];
    logic signed [7:0]  w_mem   [90];
    logic signed [23:0] b_mem   [10];

    conv_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_row(out_row), .out_col(out_col), .chan_last(chan_last)
    );

    always @(posedge clk) begin
        if (img_rd_en) img_data <= img_mem[img_addr];
        if (w_rd_en)   w_data   <= w_mem[w_addr];
        if (b_rd_en)   b_data   <= b_mem[b_addr];
    end

    // padded, strided, two-input-channel instance
    logic               g_start, g_busy, g_done, g_img_rd_en, g_w_rd_en, g_b_rd_en;
    logic               g_out_valid, g_out_ready, g_chan_last, g_b_addr, g_out_chan;
    logic [8:0]         g_img_addr;
    logic [7:0]         g_img_data;
    logic [5:0]         g_w_addr;
    logic signed [7:0]  g_w_data;
    logic signed [23:0] g_b_data, g_out_data;
    logic [2:0]         g_out_row, g_out_col;

    conv_engine #(.IN_CH(2), .OUT_CH(2), .STRIDE(2), .PAD(1)) g_dut (
        .clk(clk), .rst_n(rst_n), .start(g_start), .busy(g_busy), .done(g_done),
        .img_rd_en(g_img_rd_en), .img_addr(g_img_addr), .img_data(g_img_data),
        .w_rd_en(g_w_rd_en), .w_addr(g_w_addr), .w_data(g_w_data),
        .b_rd_en(g_b_rd_en), .b_addr(g_b_addr), .b_data(g_b_data),
        .out_valid(g_out_valid), .out_ready(g_out_ready), .out_data(g_out_data),
        .out_chan(g_out_chan), .out_row(g_out_row), .out_col(g_out_col), .chan_last(g_chan_last)
    );

    always @(posedge clk) begin
        if (g_img_rd_en) g_img_data <= (g_img_addr < 9'd480) ? 8'd1 : 8'hxx;
        if (g_w_rd_en)   g_w_data   <= 8'sd1;
        if (g_b_rd_en)   g_b_data   <= 24'sd0;
    end

    exp_t  q[$];
    gexp_t gq[$];
    int    hs_cnt = 0, g_hs_cnt = 0, done_cnt = 0;

    // monitors: pop expectation on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pix: unexpected output ch=%0d r=%0d c=%0d d=%0d", out_chan, out_row, out_col, out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({out_data, out_chan, out_row, out_col, chan_last} !== e) begin
                    errors++;
                    $display("FAIL pix %0d: got d=%0d ch=%0d r=%0d c=%0d last=%0b expected d=%0d ch=%0d r=%0d c=%0d last=%0b",
                             hs_cnt, out_data, out_chan, out_row, out_col, chan_last,
                             $signed(e.d), e.ch, e.r, e.c, e.last);
                end
            end
            hs_cnt++;
        end
        if (rst_n && done) done_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && g_out_valid && g_out_ready) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL gpix: unexpected output ch=%0d r=%0d c=%0d d=%0d", g_out_chan, g_out_row, g_out_col, g_out_data);
            end else begin
                gexp_t e;
                e = gq.pop_front();
                if ({g_out_data, g_out_chan, g_out_row, g_out_col, g_chan_last} !== e) begin
                    errors++;
                    $display("FAIL gpix %0d: got d=%0d ch=%0d r=%0d c=%0d last=%0b expected d=%0d ch=%0d r=%0d c=%0d last=%0b",
                             g_hs_cnt, g_out_data, g_out_chan, g_out_row, g_out_col, g_chan_last,
                             $signed(e.d), e.ch, e.r, e.c, e.last);
                end
            end
            g_hs_cnt++;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("handshake count reached", int'(hs_cnt >= target), 1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(done), 1);
    endtask

    // mode 0: identity on ramp, 1: all-ones kernel on 255 image, 2: zero weights with bias -1000
    task automatic push_layer(input int mode);
        for (int oc = 0; oc < 10; oc++)
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 13; c++) begin
                    int d;
                    d = mode == 0 ? (r + 1) * 15 + c + 1 : mode == 1 ? 2295 : RELU_EXP;
                    q.push_back({24'(d), 4'(oc), 4'(r), 4'(c), r == 13 && c == 12});
                end
    endtask

    task automatic abort_layer();
        @(negedge clk) rst_n = 0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort done", int'(done), 0);
        chk("abort w_rd_en", int'(w_rd_en), 0);
        q.delete();
        hs_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    function automatic int g_model(input int r, input int c);
        int n = 0;
        for (int ic = 0; ic < 2; ic++)
            for (int kh = 0; kh < 3; kh++)
                for (int kw = 0; kw < 3; kw++) begin
                    int ir, icl;
                    ir  = r * 2 - 1 + kh;
                    icl = c * 2 - 1 + kw;
                    if (ir >= 0 && ir < 16 && icl >= 0 && icl < 15) n++;
                end
        return n;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, saved;
        rst_n = 0; start = 0; out_ready = 1; g_start = 0; g_out_ready = 1;
        for (int i = 0; i < 240; i++) img_mem[i] = 8'(i);
        for (int i = 0; i < 90; i++)  w_mem[i] = (i % 9 == 4) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < 10; i++)  b_mem[i] = 24'sd0;
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset rd strobes", int'({img_rd_en, w_rd_en, b_rd_en}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("idle busy", int'(busy), 0);

        // padded/strided layer: corner 8, edge 12, interior 18
        chk("g model corner", g_model(0, 0), 8);
        chk("g model edge", g_model(0, 3), 12);
        chk("g model interior", g_model(3, 3), 18);
        for (int oc = 0; oc < 2; oc++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    gq.push_back({24'(g_model(r, c)), 1'(oc), 3'(r), 3'(c), r == 7 && c == 7});
        @(negedge clk) g_start = 1;
        @(negedge clk) g_start = 0;
        n = 0;
        while (!g_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("g done seen", int'(g_done), 1);
        chk("g pixel count", g_hs_cnt, 128);
        chk("g queue drained", gq.size(), 0);

        // identity kernel on ramp with a 5-cycle stall at pixel (0,3,4)
        push_layer(0);
        pulse_start();
        chk("busy after start", int'(busy), 1);
        wait_hs(43, 1000);
        @(negedge clk) out_ready = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("stall valid", int'(out_valid), 1);
        repeat (5) begin
            chk("stall out_valid held", int'(out_valid), 1);
            chk("stall out_row", int'(out_row), 3);
            chk("stall out_col", int'(out_col), 4);
            chk("stall out_data", int'(out_data), 65);
            @(negedge clk);
        end
        out_ready = 1;
        pulse_start();
        wait_done("identity done", 25000);
        chk("identity pixel count", hs_cnt, 1820);
        chk("identity queue drained", q.size(), 0);
        @(negedge clk);
        chk("busy after done", int'(busy), 0);
        chk("done pulse count", done_cnt, 1);

        // all-ones kernel on saturated image, aborted mid-MAC of pixel 50, then rerun
        for (int i = 0; i < 240; i++) img_mem[i] = 8'd255;
        for (int i = 0; i < 90; i++)  w_mem[i] = 8'sd1;
        hs_cnt = 0;
        push_layer(1);
        pulse_start();
        wait_hs(50, 1000);
        repeat (4) @(negedge clk);
        saved = done_cnt;
        abort_layer();
        repeat (3) @(negedge clk);
        chk("no done after abort", done_cnt, saved);
        push_layer(1);
        pulse_start();
        wait_done("ones done", 25000);
        chk("ones pixel count", hs_cnt, 1820);
        chk("ones queue drained", q.size(), 0);

        // negative bias with zero weights (ReLU-dependent)
        for (int i = 0; i < 90; i++) w_mem[i] = 8'sd0;
        for (int i = 0; i < 10; i++) b_mem[i] = -24'sd1000;
        hs_cnt = 0;
        @(negedge clk);
        push_layer(2);
        pulse_start();
        wait_hs(20, 1000);
        abort_layer();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
- Parametrised second-generation convolution layer engine.
- Computes OUT_CH output feature maps from an IN_CH-channel image with configurable kernel, stride and zero padding.
- Uses one time-multiplexed MAC and adds a per-channel bias.
- Reads image, weight and bias memories through synchronous read ports and streams output pixels over a valid/ready handshake to the pooling/buffer stage.

Parameters:
- DATA_W, 8, unsigned image pixel width
- WGT_W, 8, signed weight width
- ACC_W, 24, signed accumulator, bias and output width
- IN_H, 16, input height
- IN_W, 15, input width
- IN_CH, 1, input channels
- OUT_CH, 10, output channels
- K_H, 3, kernel height
- K_W, 3, kernel width
- STRIDE, 1, stride applied in both dimensions
- PAD, 0, zero-padding rows/cols on each border

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a layer when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel handshake
- img_rd_en  out  1  image read strobe
- img_addr  out  clog2(IN_CH*IN_H*IN_W)  address = (ic*IN_H+r)*IN_W+c
- img_data  in  DATA_W  valid exactly 1 cycle after img_rd_en
- w_rd_en  out  1  weight read strobe
- w_addr  out  clog2(OUT_CH*IN_CH*K_H*K_W)  address = ((oc*IN_CH+ic)*K_H+kh)*K_W+kw
- w_data  in  WGT_W  valid 1 cycle after w_rd_en
- b_rd_en  out  1  bias read strobe
- b_addr  out  clog2(OUT_CH)  bias address = oc
- b_data  in  ACC_W  valid 1 cycle after b_rd_en
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  signed result
- out_chan  out  clog2(OUT_CH)  output channel of out_data
- out_row  out  clog2(OUT_H)  output row
- out_col  out  clog2(OUT_W)  output column
- chan_last  out  1  qualifies the last pixel of a channel

Behaviour:
- Derived dimensions:
  - OUT_H = (IN_H+2*PAD-K_H)/STRIDE+1
  - OUT_W = (IN_W+2*PAD-K_W)/STRIDE+1
  - TAPS = IN_CH*K_H*K_W
- Reset: asynchronous. All outputs are 0, the FSM is in IDLE and the accumulator is 0.
- Loop order: oc (outer), then row, then col. Within a pixel: ic, then kh, then kw.
- FSM states:
  - IDLE: start -> BIAS. start is ignored while busy.
  - BIAS: issue b_rd_en for oc; next cycle load acc <= b_data; -> MAC.
  - MAC: issue one tap read per cycle for TAPS cycles; each product is accumulated one cycle after its read. After the last product lands -> OUT.
  - OUT: out_valid high; hold all out_* stable until out_ready. On the handshake, advance col/row/oc:
    - next pixel -> BIAS;
    - after oc=OUT_CH-1, last pixel -> DONE.
  - DONE: pulse done, drop busy, -> IDLE.
- Latency: TAPS+3 cycles per pixel when out_ready is held high. No output is produced before the first BIAS completes.
- Padding taps (input row or col outside [0,IN_H)/[0,IN_W)):
  - no image read is issued;
  - the operand is forced to 0;
  - the weight read is still issued, keeping timing constant.
- Arithmetic:
  - product = zero-extended pixel * signed weight, DATA_W+WGT_W+1 bits, sign-extended to ACC_W;
  - accumulation is two's-complement wrap, no saturation;
  - bias is added first.
- out_ready high while out_valid is low has no effect. out_valid never drops without a handshake.
- Reset mid-layer aborts immediately. No done is issued; the next start restarts from oc=0, row 0, col 0.

Optional Feature:
- Macro: CONV_ENGINE_RELU_EN.
- Defined: out_data = (acc<0) ? 0 : acc.
- Undefined: out_data = acc unchanged.
- Timing is identical either way.

Decomposition:
- Package conv_pkg:
  - FSM state enum (IDLE, BIAS, MAC, OUT, DONE);
  - derived-dimension functions out_dim(in,k,pad,stride);
  - address-width helpers.
- Sub-module mac_unit:
  - registered multiply-accumulate with load (bias), accumulate-enable and zero-operand inputs;
  - one-cycle pipeline.

Test Plan:
- Identity kernel (centre=1, rest 0), bias 0, ramp image in[r][c]=r*IN_W+c, defaults -> out[oc][r][c]=in[r+1][c+1] for every oc, 10*14*13 pixels, then done.
- All weights 1, image all 255, bias 0 -> every out_data=2295.
- Generic: IN_CH=2, STRIDE=2, PAD=1, image all 1, weights 1 -> OUT 8x8 for IN 16x15; corner=8, edge=12, interior=18.
- out_ready low for 5 cycles at pixel (0,3,4) -> out_data/row/col stable and out_valid held; no pixel lost or duplicated; order preserved.
- Reset asserted during MAC of pixel 50 -> busy, out_valid, done=0 immediately; new start gives pixel (0,0,0) correct.
- Bias -1000, zero weights -> with CONV_ENGINE_RELU_EN out_data=0; without, out_data=-1000.
